// File: rtl/text_banner_ctrl.sv
// text_banner_ctrl: frame-synchronous reveal/blink sequencer driving the banner glyph renderers
module text_banner_ctrl #(
  parameter int BASE_X = 192,
  parameter int BASE_Y = 220,
  parameter int TYPE_FRAMES = 6,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [1:0] msg_sel,
  input  logic       show_req,
  input  logic       hide_req,
  output logic [9:0] start_x,
  output logic [9:0] start_y,
  output logic [4:0] char_code,
  output logic       char_en,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, TYPE, HOLD} state_t;
  state_t state, state_n;
  logic [1:0] cur_msg, cur_msg_n, pend_msg, pend_msg_n;
  logic [3:0] revealed, revealed_n, msg_len;
  logic [7:0] fcnt, fcnt_n;
  logic blink_on, blink_n, show_pend, show_n, hide_pend, hide_n;
  logic [9:0] dx, dy;
  logic in_span, vis;
  logic [2:0] slot;
  logic [4:0] code;

  function automatic logic [4:0] rom(input logic [1:0] m, input logic [2:0] s);
    case ({m, s})
      5'd0:  rom = 5'd16;
      5'd1:  rom = 5'd15;
      5'd2:  rom = 5'd14;
      5'd3:  rom = 5'd7;
      5'd8:  rom = 5'd16;
      5'd9:  rom = 5'd27;
      5'd11: rom = 5'd23;
      5'd12: rom = 5'd9;
      5'd13: rom = 5'd14;
      5'd16: rom = 5'd16;
      5'd17: rom = 5'd28;
      5'd19: rom = 5'd23;
      5'd20: rom = 5'd9;
      5'd21: rom = 5'd14;
      5'd24: rom = 5'd16;
      5'd25: rom = 5'd1;
      5'd26: rom = 5'd21;
      5'd27: rom = 5'd19;
      5'd28: rom = 5'd5;
      default: rom = 5'd0;
    endcase
  endfunction

  assign msg_len = cur_msg == 2'd0 ? 4'd4 : cur_msg == 2'd3 ? 4'd5 : 4'd6;
  assign busy = state != IDLE || show_pend;

  always_comb begin
    state_n = state;
    cur_msg_n = cur_msg;
    revealed_n = revealed;
    fcnt_n = fcnt;
    blink_n = blink_on;
    show_n = show_pend;
    hide_n = hide_pend;
    pend_msg_n = pend_msg;
    if (frame_tick) begin
      show_n = 1'b0;
      hide_n = 1'b0;
      if (hide_pend) begin
        state_n = IDLE;
        revealed_n = 4'd0;
        blink_n = 1'b0;
        fcnt_n = 8'd0;
      end else if (show_pend) begin
        state_n = TYPE;
        cur_msg_n = pend_msg;
        revealed_n = 4'd1;
        fcnt_n = 8'd0;
        blink_n = 1'b0;
      end else if (state == TYPE) begin
        if (fcnt == 8'(TYPE_FRAMES - 1)) begin
          fcnt_n = 8'd0;
          revealed_n = revealed + 4'd1;
          if (revealed + 4'd1 == msg_len) begin
            state_n = HOLD;
            blink_n = 1'b1;
          end
        end else fcnt_n = fcnt + 8'd1;
      end else if (state == HOLD) begin
        fcnt_n = fcnt == 8'(BLINK_FRAMES - 1) ? 8'd0 : fcnt + 8'd1;
        blink_n = fcnt == 8'(BLINK_FRAMES - 1) ? ~blink_on : blink_on;
      end
    end
    // new requests land after any tick application, so a same-cycle request waits a frame
    if (hide_req) begin
      show_n = 1'b0;
      hide_n = 1'b1;
    end else if (show_req) begin
      show_n = 1'b1;
      hide_n = 1'b0;
      pend_msg_n = msg_sel;
    end
  end

  assign dx = x - 10'(BASE_X);
  assign dy = y - 10'(BASE_Y);
  assign in_span = x >= 10'(BASE_X) && dx < 10'd256 && y >= 10'(BASE_Y) && dy < 10'd40;
  assign slot = dx[7:5];
  assign code = rom(cur_msg, slot);
  assign vis = state != IDLE && in_span && {1'b0, slot} < revealed && code != 5'd0
               && (state == TYPE || blink_on);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur_msg <= 2'd0;
      pend_msg <= 2'd0;
      revealed <= 4'd0;
      fcnt <= 8'd0;
      blink_on <= 1'b0;
      show_pend <= 1'b0;
      hide_pend <= 1'b0;
      start_x <= 10'd0;
      start_y <= 10'd0;
      char_code <= 5'd0;
      char_en <= 1'b0;
    end else begin
      state <= state_n;
      cur_msg <= cur_msg_n;
      pend_msg <= pend_msg_n;
      revealed <= revealed_n;
      fcnt <= fcnt_n;
      blink_on <= blink_n;
      show_pend <= show_n;
      hide_pend <= hide_n;
      char_en <= vis;
      char_code <= vis ? code : 5'd0;
      if (in_span) begin
        start_x <= 10'(BASE_X) + {2'b00, slot, 5'b00000};
        start_y <= 10'(BASE_Y);
      end
    end
  end
endmodule

// File: tb/tb_text_banner_ctrl.sv
// tb_text_banner_ctrl: directed tables plus randomized traffic against a tick-count reference model
module tb_text_banner_ctrl;
  localparam int BX = 192, BY = 220, TF = 6, BF = 30;
  logic clk = 0, rst_n = 0, frame_tick = 0, show_req = 0, hide_req = 0;
  logic [9:0] x = 0, y = 0;
  logic [1:0] msg_sel = 0;
  logic [9:0] start_x, start_y;
  logic [4:0] char_code;
  logic char_en, busy;

  text_banner_ctrl #(.BASE_X(BX), .BASE_Y(BY), .TYPE_FRAMES(TF), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .x(x), .y(y), .msg_sel(msg_sel),
    .show_req(show_req), .hide_req(hide_req), .start_x(start_x), .start_y(start_y),
    .char_code(char_code), .char_en(char_en), .busy(busy));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int glyph [4][8] = '{'{16,15,14,7,0,0,0,0}, '{16,27,0,23,9,14,0,0},
                       '{16,28,0,23,9,14,0,0}, '{16,1,21,19,5,0,0,0}};
  int lens [4] = '{4, 6, 6, 5};
  bit m_act, m_sp, m_hp;
  int m_msg, m_pm, m_t, e_en, e_code, e_sx, e_sy;

  typedef struct {int px; int py; int en; int code; int sx;} vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_sp = 0; m_hp = 0; m_msg = 0; m_pm = 0; m_t = 0;
    e_en = 0; e_code = 0; e_sx = 0; e_sy = 0;
  endtask

  // Model state is "ticks since the message was shown"; reveal and blink follow by division.
  task automatic cyc();
    int xi, yi, len, th, slot, rev, code;
    bit typ, blink, ft, sr, hr;
    int ms;
    xi = int'(x); yi = int'(y); len = lens[m_msg]; th = (len - 1) * TF;
    ft = frame_tick; sr = show_req; hr = hide_req; ms = int'(msg_sel);
    if (xi >= BX && xi <= BX + 255 && yi >= BY && yi <= BY + 39) begin
      slot = (xi - BX) / 32;
      rev = 1 + m_t / TF;
      if (rev > len) rev = len;
      typ = m_t < th;
      blink = typ ? 1'b0 : ((m_t - th) / BF) % 2 == 0;
      code = glyph[m_msg][slot];
      e_en = (m_act && slot < rev && code != 0 && (typ || blink)) ? 1 : 0;
      e_code = e_en ? code : 0;
      e_sx = BX + 32 * slot;
      e_sy = BY;
    end else begin
      e_en = 0;
      e_code = 0;
    end
    @(posedge clk);
    if (ft) begin
      if (m_hp) m_act = 0;
      else if (m_sp) begin m_act = 1; m_msg = m_pm; m_t = 0; end
      else if (m_act) m_t++;
      m_sp = 0; m_hp = 0;
    end
    if (hr) begin m_sp = 0; m_hp = 1; end
    else if (sr) begin m_sp = 1; m_hp = 0; m_pm = ms; end
    #1;
    chk("char_en", int'(char_en), e_en);
    chk("char_code", int'(char_code), e_code);
    chk("start_x", int'(start_x), e_sx);
    chk("start_y", int'(start_y), e_sy);
    chk("busy", int'(busy), (m_act || m_sp) ? 1 : 0);
  endtask

  task automatic probe(input string nm, input int px, input int py, input int en, input int code, input int sx);
    x = 10'(px); y = 10'(py);
    cyc();
    chk({nm, ".en"}, int'(char_en), en);
    chk({nm, ".code"}, int'(char_code), code);
    chk({nm, ".sx"}, int'(start_x), sx);
  endtask

  task automatic tick(input int idle);
    frame_tick = 1;
    cyc();
    frame_tick = 0;
    repeat (idle) begin
      x = 10'($urandom_range(150, 500)); y = 10'($urandom_range(200, 280));
      cyc();
    end
  endtask

  task automatic req_show(input int m);
    msg_sel = 2'(m); show_req = 1;
    cyc();
    show_req = 0;
  endtask

  initial begin
    tbl[0]  = '{192, 220, 1, 16, 192};
    tbl[1]  = '{224, 230, 1, 27, 224};
    tbl[2]  = '{256, 220, 0, 0, 256};
    tbl[3]  = '{288, 259, 1, 23, 288};
    tbl[4]  = '{320, 220, 1, 9, 320};
    tbl[5]  = '{383, 240, 1, 14, 352};
    tbl[6]  = '{384, 220, 0, 0, 384};
    tbl[7]  = '{447, 220, 0, 0, 416};
    tbl[8]  = '{191, 220, 0, 0, 416};
    tbl[9]  = '{448, 220, 0, 0, 416};
    tbl[10] = '{300, 219, 0, 0, 416};
    tbl[11] = '{300, 260, 0, 0, 416};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("por.en", int'(char_en), 0);
    chk("por.code", int'(char_code), 0);
    chk("por.sx", int'(start_x), 0);
    chk("por.sy", int'(start_y), 0);
    chk("por.busy", int'(busy), 0);
    rst_n = 1;
    // reset while holding a message
    req_show(0);
    repeat (19) tick(3);
    probe("hold", 192, 220, 1, 16, 192);
    rst_n = 0;
    #1;
    chk("rst.en", int'(char_en), 0);
    chk("rst.code", int'(char_code), 0);
    chk("rst.sx", int'(start_x), 0);
    chk("rst.sy", int'(start_y), 0);
    chk("rst.busy", int'(busy), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) begin
      tick(3);
      probe("rst_hidden", 192, 220, 0, 0, 192);
    end
    // show requested mid-frame waits for the tick
    x = 192; y = 220;
    req_show(0);
    repeat (3) begin
      cyc();
      chk("pre_tick.en", int'(char_en), 0);
    end
    tick(0);
    probe("show0", 192, 220, 1, 16, 192);
    probe("show0_s1", 224, 220, 0, 0, 224);
    repeat (17) tick(3);
    probe("type17", 288, 220, 0, 0, 288);
    tick(0);
    probe("type18", 288, 220, 1, 7, 288);
    probe("type18_s4", 320, 220, 0, 0, 320);
    for (int k = 1; k < 60; k++) begin
      tick(2);
      probe($sformatf("blink%0d", k), 192, 220, k < 30 ? 1 : 0, k < 30 ? 16 : 0, 192);
    end
    // msg 1 fully revealed, blink on
    req_show(1);
    repeat (31) tick(2);
    for (int i = 0; i < 12; i++)
      probe($sformatf("tbl%0d", i), tbl[i].px, tbl[i].py, tbl[i].en, tbl[i].code, tbl[i].sx);
    // simultaneous show and hide: hide wins
    msg_sel = 2; show_req = 1; hide_req = 1;
    cyc();
    show_req = 0; hide_req = 0;
    tick(0);
    probe("arb", 192, 220, 0, 0, 192);
    chk("arb.busy", int'(busy), 0);
    // request coinciding with a tick waits for the next one
    msg_sel = 0; show_req = 1; frame_tick = 1;
    cyc();
    show_req = 0; frame_tick = 0;
    chk("coinc.busy", int'(busy), 1);
    probe("coinc.idle", 192, 220, 0, 0, 192);
    tick(0);
    probe("coinc.type", 192, 220, 1, 16, 192);
    repeat (18) tick(2);
    probe("hold0", 288, 220, 1, 7, 288);
    // restart during HOLD with msg 3
    req_show(3);
    tick(0);
    probe("restart", 192, 220, 1, 16, 192);
    probe("restart_s1", 224, 220, 0, 0, 224);
    probe("left_edge", 191, 220, 0, 0, 224);
    probe("right_edge", 448, 220, 0, 0, 224);
    repeat (4000) begin
      frame_tick = $urandom_range(0, 11) == 0;
      show_req = $urandom_range(0, 399) == 0;
      hide_req = $urandom_range(0, 799) == 0;
      msg_sel = 2'($urandom);
      x = 10'($urandom_range(150, 500));
      y = 10'($urandom_range(200, 280));
      cyc();
    end
    frame_tick = 0; show_req = 0; hide_req = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
